// File: rtl/twpm_wb_pkg.sv
// Shared Wishbone definitions for the TwPM bus fabric: router FSM states,
// default read filler and response encoding helpers.
package twpm_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } wb_state_e;

  localparam logic [31:0] WB_DEFAULT_READ_VALUE = 32'hBADFABAC;

  typedef struct packed {
    logic ack;
    logic err;
  } wb_resp_t;

  // Err always dominates, so a master never sees ack and err together.
  function automatic wb_resp_t wb_resp_encode(input logic ack, input logic err);
    wb_resp_t r;
    r.err = err;
    r.ack = ack & ~err;
    return r;
  endfunction

  function automatic wb_resp_t wb_resp_unmapped(input logic err_on_unmapped);
    return wb_resp_encode(~err_on_unmapped, err_on_unmapped);
  endfunction

  // Slave index width that stays legal for a single-slave fabric.
  function automatic int unsigned wb_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_region_match.sv
// Combinational address decoder: reports whether an address falls in any
// slave region and which one, with the lowest index winning on overlap.
module wb_region_match
  import twpm_wb_pkg::*;
#(
  parameter int                       NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS  = {32'hF8000000, 32'hF0000800,
                                                     32'hF0000000, 32'h80000000},
  parameter logic [NUM_SLAVES*8-1:0]  ADDR_WIDTHS = {8'd14, 8'd11, 8'd11, 8'd27},
  localparam int                      IDX_W       = wb_idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      adr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [NUM_SLAVES-1:0] hits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      localparam int unsigned W    = int'(ADDR_WIDTHS[8*gi +: 8]);
      localparam logic [31:0] MASK = (W >= 32) ? 32'h0 : (32'hFFFF_FFFF << W);
      assign hits[gi] = ((adr ^ BASE_ADDRS[32*gi +: 32]) & MASK) == 32'h0;
    end
  endgenerate

  // Scan downwards so the last assignment is the lowest matching index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_region_router.sv
// Wishbone B4 classic single-master, N-slave router with registered
// one-at-a-time sequencing, per-transfer timeout and unmapped-access policy.
module wb_region_router
  import twpm_wb_pkg::*;
#(
  parameter int                       NUM_SLAVES         = 4,
  parameter int                       DATA_W             = 32,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS         = {32'hF8000000, 32'hF0000800,
                                                            32'hF0000000, 32'h80000000},
  parameter logic [NUM_SLAVES*8-1:0]  ADDR_WIDTHS        = {8'd14, 8'd11, 8'd11, 8'd27},
  parameter int                       TIMEOUT_CYCLES     = 255,
  parameter logic [31:0]              DEFAULT_READ_VALUE = twpm_wb_pkg::WB_DEFAULT_READ_VALUE,
  parameter bit                       ERR_ON_UNMAPPED    = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [31:0]                  m_adr_i,
  input  logic [DATA_W-1:0]            m_dat_i,
  output logic [DATA_W-1:0]            m_dat_o,
  input  logic                         m_we_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic                         m_stb_i,
  input  logic                         m_cyc_i,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [31:0]                  s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic                         s_we_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  input  logic [NUM_SLAVES-1:0]        s_err_i,
  output logic                         timeout_o,
  output logic                         busy_o
);

  localparam int          SEL_W      = DATA_W / 8;
  localparam int          IDX_W      = wb_idx_width(NUM_SLAVES);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_SLAVES-1:0] SLOT_ONE = NUM_SLAVES'(1);

  wb_state_e               state_reg, state_next;
  logic [15:0]             cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [31:0]             adr_reg, adr_next;
  logic [DATA_W-1:0]       wdat_reg, wdat_next;
  logic [SEL_W-1:0]        sel_reg, sel_next;
  logic                    we_reg, we_next;
  logic [NUM_SLAVES-1:0]   stb_reg, stb_next;
  logic                    ack_reg, ack_next;
  logic                    err_reg, err_next;
  logic [DATA_W-1:0]       rdat_reg, rdat_next;
  logic                    tmo_reg, tmo_next;

  logic                    match_hit;
  logic [IDX_W-1:0]        match_idx;
  logic                    slave_ack;
  logic                    slave_err;
  logic [DATA_W-1:0]       slave_dat;
  wb_resp_t                resp;

  wb_region_match #(
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDRS  (BASE_ADDRS),
    .ADDR_WIDTHS (ADDR_WIDTHS)
  ) u_match (
    .adr (m_adr_i),
    .hit (match_hit),
    .idx (match_idx)
  );

  assign slave_ack = s_ack_i[idx_reg];
  assign slave_err = s_err_i[idx_reg];
  assign slave_dat = s_dat_i[idx_reg*DATA_W +: DATA_W];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    stb_next   = stb_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    tmo_next   = 1'b0;
    rdat_next  = rdat_reg;
    resp       = '0;

    case (state_reg)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_next  = m_adr_i;
          wdat_next = m_dat_i;
          sel_next  = m_sel_i;
          we_next   = m_we_i;
          idx_next  = match_idx;
          cnt_next  = '0;
          if (match_hit) begin
            stb_next   = SLOT_ONE << match_idx;
            state_next = ST_ACTIVE;
          end else begin
            // Unmapped: answer locally, the write never reaches a slave.
            resp       = wb_resp_unmapped(ERR_ON_UNMAPPED);
            ack_next   = resp.ack;
            err_next   = resp.err;
            rdat_next  = m_we_i ? '0 : DATA_W'(DEFAULT_READ_VALUE);
            state_next = ST_RESP;
          end
        end
      end

      ST_ACTIVE: begin
        if (!m_cyc_i) begin
          stb_next   = '0;
          state_next = ST_IDLE;
        end else if (slave_ack || slave_err) begin
          resp       = wb_resp_encode(slave_ack, slave_err);
          ack_next   = resp.ack;
          err_next   = resp.err;
          rdat_next  = we_reg ? '0 : slave_dat;
          stb_next   = '0;
          state_next = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_reg == TMO_LAST)) begin
          err_next   = 1'b1;
          tmo_next   = 1'b1;
          rdat_next  = '0;
          stb_next   = '0;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        stb_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      stb_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdat_reg  <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      stb_reg   <= stb_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rdat_reg  <= rdat_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign m_dat_o   = rdat_reg;
  assign m_ack_o   = ack_reg;
  assign m_err_o   = err_reg;
  assign s_adr_o   = adr_reg;
  assign s_dat_o   = wdat_reg;
  assign s_sel_o   = sel_reg;
  assign s_we_o    = we_reg;
  assign s_cyc_o   = stb_reg;
  assign s_stb_o   = stb_reg;
  assign timeout_o = tmo_reg;
  assign busy_o    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wb_region_router.sv
// Scoreboard bench for wb_region_router: one instance with an 8-cycle
// timeout and err-on-unmapped, a second one with ack-on-unmapped.
module tb_wb_region_router;

  localparam int NS = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [31:0]       m_adr;
  logic [DW-1:0]     m_wdat;
  logic              m_we;
  logic [DW/8-1:0]   m_sel;
  logic              m_stb;
  logic              m_cyc;
  logic [NS*DW-1:0]  s_dat;
  logic [NS-1:0]     s_ack;
  logic [NS-1:0]     s_err;

  logic [DW-1:0]     m_rdat, m_rdat2;
  logic              m_ack, m_ack2, m_err, m_err2;
  logic [31:0]       s_adr, s_adr2;
  logic [DW-1:0]     s_wdat, s_wdat2;
  logic [DW/8-1:0]   s_sel, s_sel2;
  logic              s_we, s_we2;
  logic [NS-1:0]     s_cyc, s_cyc2, s_stb, s_stb2;
  logic              tmo, tmo2, busy, busy2;

  wb_region_router #(.TIMEOUT_CYCLES(8), .ERR_ON_UNMAPPED(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_dat_o(m_rdat), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .timeout_o(tmo), .busy_o(busy)
  );

  wb_region_router #(.ERR_ON_UNMAPPED(1'b0)) dut_alt (
    .clk_i(clk), .rstn_i(rstn),
    .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_dat_o(m_rdat2), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_ack_o(m_ack2), .m_err_o(m_err2),
    .s_adr_o(s_adr2), .s_dat_o(s_wdat2), .s_sel_o(s_sel2), .s_we_o(s_we2),
    .s_cyc_o(s_cyc2), .s_stb_o(s_stb2),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .timeout_o(tmo2), .busy_o(busy2)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    bit          chk_dat;
    int          cyc;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic        alt_ack, alt_err;
  logic [31:0] alt_dat;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // One master transfer; slave slv answers in its (lat+1)-th strobe cycle,
  // lat < 0 means the slave never answers.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic we,
                      input logic [31:0] wdat, input logic [3:0] sel,
                      input int slv, input int lat, input logic r_ack, input logic r_err,
                      input logic [31:0] rdat,
                      input logic e_ack, input logic e_err, input logic [31:0] e_dat,
                      input bit chk_dat, input int e_cyc, input logic e_tmo);
    exp_t e;
    exp_t got;
    int   cyc;
    int   stb_cnt;
    bit   done;
    logic [NS-1:0] oh;
    @(posedge clk); #1;
    m_adr = adr; m_we = we; m_wdat = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    e.ack = e_ack; e.err = e_err; e.dat = e_dat; e.chk_dat = chk_dat;
    e.cyc = e_cyc; e.tmo = e_tmo;
    sb_q.push_back(e);
    @(posedge clk);
    cyc = 0; stb_cnt = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      s_ack = '0;
      s_err = '0;
      if (m_ack || m_err) begin
        got = sb_q.pop_front();
        check({tag, "_ack"}, m_ack, got.ack);
        check({tag, "_err"}, m_err, got.err);
        if (got.chk_dat) check({tag, "_dat"}, m_rdat, got.dat);
        check({tag, "_cycle"}, cyc, got.cyc);
        check({tag, "_timeout"}, tmo, got.tmo);
        check({tag, "_stb_cycles"}, stb_cnt, cyc - 1);
        check({tag, "_stb_off"}, s_stb, 0);
        alt_ack = m_ack2; alt_err = m_err2; alt_dat = m_rdat2;
        done = 1'b1;
      end else if (s_stb != 0) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          oh = NS'(1) << slv;
          check({tag, "_stb"}, s_stb, oh);
          check({tag, "_cyc"}, s_cyc, oh);
          check({tag, "_s_adr"}, s_adr, adr);
          check({tag, "_s_we"}, s_we, we);
          if (we) begin
            check({tag, "_s_dat"}, s_wdat, wdat);
            check({tag, "_s_sel"}, s_sel, sel);
          end
        end
        if (lat >= 0 && stb_cnt == lat + 1) begin
          s_ack[slv] = r_ack;
          s_err[slv] = r_err;
          s_dat[slv*DW +: DW] = rdat;
        end
      end
    end
    if (!done) begin
      check({tag, "_no_response"}, 0, 1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    s_ack = '0;
    s_err = '0;
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    $display("xfer %s adr=0x%08h we=%0b ack=%0b err=%0b dat=0x%08h cycles=%0d",
             tag, adr, we, alt_ack | m_ack, m_err, m_rdat, cyc);
  endtask

  // Start a read to slave 0, then abandon it in ACTIVE cycle 2.
  task automatic abort_xfer(input string tag, input bit use_reset);
    bit resp_seen;
    @(posedge clk); #1;
    m_adr = 32'h8000_0040; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_stb_c1"}, s_stb, 4'b0001);
    @(posedge clk); #1;
    if (use_reset) rstn = 1'b0;
    else begin
      m_cyc = 1'b0; m_stb = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_stb_off"}, s_stb, 0);
    check({tag, "_cyc_off"}, s_cyc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_resp"}, {m_ack, m_err}, 2'b00);
    if (use_reset) check({tag, "_s_adr"}, s_adr, 0);
    @(posedge clk); #1;
    rstn = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    resp_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_ack || m_err || s_stb != 0) resp_seen = 1'b1;
    end
    check({tag, "_quiet"}, resp_seen, 0);
    $display("abort %s ack=%0b err=%0b busy=%0b", tag, m_ack, m_err, busy);
  endtask

  initial begin
    logic [31:0] radr, rdat;
    int          rlat;
    rstn = 1'b0; m_adr = '0; m_wdat = '0; m_we = 1'b0; m_sel = '0;
    m_stb = 1'b0; m_cyc = 1'b0; s_ack = '0; s_err = '0;
    s_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    alt_ack = 1'b0; alt_err = 1'b0; alt_dat = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_outputs", {m_ack, m_err, tmo, busy, s_we, s_stb, s_cyc}, 0);
    check("reset_buses", {m_rdat, s_adr}, 0);
    check("reset_wbus", {s_wdat, s_sel}, 0);

    xfer("rd_slv1", 32'hF000_0004, 1'b0, 32'h0, 4'hF, 1, 0, 1'b1, 1'b0, 32'h0000_0005,
         1'b1, 1'b0, 32'h0000_0005, 1'b1, 2, 1'b0);
    xfer("wr_slv0", 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 2, 1'b1, 1'b0, 32'h5555_5555,
         1'b1, 1'b0, 32'h0, 1'b1, 4, 1'b0);
    xfer("rd_unmapped", 32'h0000_0000, 1'b0, 32'h0, 4'hF, -1, -1, 1'b0, 1'b0, 32'h0,
         1'b0, 1'b1, 32'hBADF_ABAC, 1'b1, 1, 1'b0);
    check("rd_unmapped_alt", {alt_ack, alt_err, alt_dat}, {1'b1, 1'b0, 32'hBADF_ABAC});
    xfer("wr_unmapped", 32'h8800_0000, 1'b1, 32'h1234_5678, 4'hF, -1, -1, 1'b0, 1'b0, 32'h0,
         1'b0, 1'b1, 32'h0, 1'b1, 1, 1'b0);
    check("wr_unmapped_alt", {alt_ack, alt_err, alt_dat}, {1'b1, 1'b0, 32'h0});
    xfer("rd_timeout", 32'hF800_0100, 1'b0, 32'h0, 4'hF, 3, -1, 1'b0, 1'b0, 32'h0,
         1'b0, 1'b1, 32'h0, 1'b0, 9, 1'b1);
    xfer("rd_ack_err", 32'hF000_0800, 1'b0, 32'h0, 4'hF, 2, 1, 1'b1, 1'b1, 32'hCAFE_0002,
         1'b0, 1'b1, 32'hCAFE_0002, 1'b1, 3, 1'b0);
    xfer("rd_slv1_top", 32'hF000_07FC, 1'b0, 32'h0, 4'hF, 1, 0, 1'b1, 1'b0, 32'h0A0B_0C0D,
         1'b1, 1'b0, 32'h0A0B_0C0D, 1'b1, 2, 1'b0);
    xfer("rd_slv3_top", 32'hF800_3FFC, 1'b0, 32'h0, 4'hF, 3, 3, 1'b1, 1'b0, 32'h7777_3333,
         1'b1, 1'b0, 32'h7777_3333, 1'b1, 5, 1'b0);
    xfer("rd_slv3_past", 32'hF800_4000, 1'b0, 32'h0, 4'hF, -1, -1, 1'b0, 1'b0, 32'h0,
         1'b0, 1'b1, 32'hBADF_ABAC, 1'b1, 1, 1'b0);
    xfer("wr_slv0_err", 32'h87FF_FFFC, 1'b1, 32'h0BAD_F00D, 4'b1100, 0, 1, 1'b0, 1'b1, 32'h0,
         1'b0, 1'b1, 32'h0, 1'b1, 3, 1'b0);

    for (int k = 0; k < 4; k++) begin
      radr = 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
      rdat = $urandom;
      rlat = int'($urandom_range(0, 3));
      xfer("rd_rand", radr, 1'b0, 32'h0, 4'hF, 0, rlat, 1'b1, 1'b0, rdat,
           1'b1, 1'b0, rdat, 1'b1, rlat + 2, 1'b0);
    end

    abort_xfer("abort_cyc", 1'b0);
    abort_xfer("abort_rst", 1'b1);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
